wfid_done_collector: RTL and testbench

// Parametrised successor to the VGPR write-port wfid mux. It captures wavefront-done events from NUM_PORTS write ports,

---
 rtl/wfid_done_collector_if.sv | 29 ++
 rtl/wfid_done_collector.sv | 101 ++++++++++
 tb/tb_wfid_done_collector.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/wfid_done_collector_if.sv
// Bundle of write-port done inputs and the registered valid/ready event output
// for wfid_done_collector.
interface wfid_done_collector_if #(
    parameter int NUM_PORTS = 8,
    parameter int WFID_W    = 6
);
    localparam int PW = $clog2(NUM_PORTS);

    logic [NUM_PORTS-1:0]        wr_port_select;
    logic [NUM_PORTS-1:0]        wfid_done;
    logic [NUM_PORTS*WFID_W-1:0] wfid;
    logic                        out_valid;
    logic                        out_ready;
    logic [WFID_W-1:0]           out_wfid;
    logic [PW-1:0]               out_port;
    logic [NUM_PORTS-1:0]        pend_mask;
    logic                        sel_err;
    logic                        ovf_err;

    modport master (
        output wr_port_select, wfid_done, wfid, out_ready,
        input  out_valid, out_wfid, out_port, pend_mask, sel_err, ovf_err
    );

    modport slave (
        input  wr_port_select, wfid_done, wfid, out_ready,
        output out_valid, out_wfid, out_port, pend_mask, sel_err, ovf_err
    );
endinterface

// File: rtl/wfid_done_collector.sv
// Captures per-port wavefront-done events, holds one pending entry per port and
// drains them one per cycle through a round-robin arbiter to a registered output.
module wfid_done_collector #(
    parameter int NUM_PORTS    = 8,
    parameter int WFID_W       = 6,
    parameter int ONEHOT_CHECK = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    wfid_done_collector_if.slave  bus
);
    localparam int PW = $clog2(NUM_PORTS);

    logic [NUM_PORTS-1:0] r_pend;
    logic [WFID_W-1:0]    r_pend_wfid [NUM_PORTS];
    logic                 r_out_valid;
    logic [WFID_W-1:0]    r_out_wfid;
    logic [PW-1:0]        r_out_port;
    logic [PW-1:0]        r_rr_ptr;
    logic                 r_sel_err;
    logic                 r_ovf_err;

    logic [NUM_PORTS-1:0] w_ev;
    logic [NUM_PORTS-1:0] w_gnt_oh;
    logic [NUM_PORTS-1:0] w_ovf;
    logic                 w_multi;
    logic                 w_load_en;
    logic                 w_gnt_vld;
    logic [PW-1:0]        w_gnt;
    logic [PW-1:0]        w_rr_next;

    // Clearing the lowest set bit leaves something only when more than one bit is set.
    assign w_multi   = |(bus.wr_port_select & (bus.wr_port_select - NUM_PORTS'(1)));
    assign w_ev      = ((ONEHOT_CHECK != 0) && w_multi) ? '0
                       : (bus.wr_port_select & bus.wfid_done);
    assign w_load_en = !r_out_valid | bus.out_ready;
    assign w_gnt_vld = w_load_en & (|r_pend);

    // Scan downward so the candidate closest to r_rr_ptr is written last and wins.
    always_comb begin
        int idx;
        w_gnt = '0;
        idx   = 0;
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
            idx = (int'(r_rr_ptr) + k) % NUM_PORTS;
            if (r_pend[idx]) begin
                w_gnt = PW'(idx);
            end
        end
    end

    assign w_gnt_oh  = w_gnt_vld ? (NUM_PORTS'(1) << w_gnt) : '0;
    assign w_ovf     = w_ev & r_pend & ~w_gnt_oh;
    assign w_rr_next = (w_gnt == PW'(NUM_PORTS - 1)) ? '0 : (w_gnt + PW'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend      <= '0;
            r_out_valid <= 1'b0;
            r_out_wfid  <= '0;
            r_out_port  <= '0;
            r_rr_ptr    <= '0;
            r_sel_err   <= 1'b0;
            r_ovf_err   <= 1'b0;
            for (int i = 0; i < NUM_PORTS; i++) begin
                r_pend_wfid[i] <= '0;
            end
        end else begin
            // A port granted this cycle frees its slot, so a new event may refill it.
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (w_ev[i] && !w_ovf[i]) begin
                    r_pend[i]      <= 1'b1;
                    r_pend_wfid[i] <= bus.wfid[i*WFID_W +: WFID_W];
                end else if (w_gnt_oh[i]) begin
                    r_pend[i] <= 1'b0;
                end
            end
            if (w_load_en) begin
                r_out_valid <= w_gnt_vld;
                if (w_gnt_vld) begin
                    r_out_wfid <= r_pend_wfid[w_gnt];
                    r_out_port <= w_gnt;
                    r_rr_ptr   <= w_rr_next;
                end
            end
            if ((ONEHOT_CHECK != 0) && w_multi) begin
                r_sel_err <= 1'b1;
            end
            if (|w_ovf) begin
                r_ovf_err <= 1'b1;
            end
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.out_wfid  = r_out_wfid;
    assign bus.out_port  = r_out_port;
    assign bus.pend_mask = r_pend;
    assign bus.sel_err   = r_sel_err;
    assign bus.ovf_err   = r_ovf_err;
endmodule

// File: tb/tb_wfid_done_collector.sv
// Directed bench for wfid_done_collector: one instance with multi-hot capture
// allowed, one with multi-hot rejected; per-cycle vector table plus corner sequences.
module tb_wfid_done_collector;
    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_fail;

    wfid_done_collector_if #(.NUM_PORTS(8), .WFID_W(6)) if0 ();
    wfid_done_collector_if #(.NUM_PORTS(8), .WFID_W(6)) if1 ();

    wfid_done_collector #(.NUM_PORTS(8), .WFID_W(6), .ONEHOT_CHECK(0)) u_dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if0)
    );

    wfid_done_collector #(.NUM_PORTS(8), .WFID_W(6), .ONEHOT_CHECK(1)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [7:0]  sel;
        logic [7:0]  done;
        logic [47:0] wfid;
        logic        ready;
        logic        exp_valid;
        logic [5:0]  exp_wfid;
        logic [2:0]  exp_port;
        logic [7:0]  exp_pend;
    } vec_t;

    vec_t vt [15];

    function automatic logic [47:0] wf1(input int p, input logic [5:0] v);
        logic [47:0] r;
        r = '0;
        r[p*6 +: 6] = v;
        return r;
    endfunction

    function automatic vec_t mk(input logic [7:0] sel, input logic [7:0] done,
                                input logic [47:0] wfid, input logic ready,
                                input logic ev, input logic [5:0] ew,
                                input logic [2:0] ep, input logic [7:0] epd);
        vec_t v;
        v.sel = sel; v.done = done; v.wfid = wfid; v.ready = ready;
        v.exp_valid = ev; v.exp_wfid = ew; v.exp_port = ep; v.exp_pend = epd;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drv1(input logic [7:0] sel, input logic [7:0] done,
                        input logic [47:0] wfid, input logic ready);
        if1.wr_port_select = sel;
        if1.wfid_done      = done;
        if1.wfid           = wfid;
        if1.out_ready      = ready;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out1(input string tag, input logic v, input logic [5:0] w,
                            input logic [2:0] p, input logic [7:0] pd);
        chk({tag, "_valid"}, 64'(if1.out_valid), 64'(v));
        if (v) begin
            chk({tag, "_wfid"}, 64'(if1.out_wfid), 64'(w));
            chk({tag, "_port"}, 64'(if1.out_port), 64'(p));
        end
        chk({tag, "_pend"}, 64'(if1.pend_mask), 64'(pd));
    endtask

    initial begin
        n_vec  = 0;
        n_fail = 0;

        vt[0]  = mk(8'h04, 8'h04, wf1(2, 6'h15), 1'b1, 1'b0, 6'h00, 3'd0, 8'h04);
        vt[1]  = mk(8'h00, 8'h00, 48'h0,         1'b1, 1'b1, 6'h15, 3'd2, 8'h00);
        vt[2]  = mk(8'h00, 8'h00, 48'h0,         1'b1, 1'b0, 6'h00, 3'd0, 8'h00);
        vt[3]  = mk(8'h00, 8'h04, wf1(2, 6'h3F), 1'b1, 1'b0, 6'h00, 3'd0, 8'h00);
        vt[4]  = mk(8'h20, 8'h20, wf1(5, 6'h07), 1'b1, 1'b0, 6'h00, 3'd0, 8'h20);
        vt[5]  = mk(8'h20, 8'h20, wf1(5, 6'h09), 1'b1, 1'b1, 6'h07, 3'd5, 8'h20);
        vt[6]  = mk(8'h00, 8'h00, 48'h0,         1'b1, 1'b1, 6'h09, 3'd5, 8'h00);
        vt[7]  = mk(8'h00, 8'h00, 48'h0,         1'b1, 1'b0, 6'h00, 3'd0, 8'h00);
        vt[8]  = mk(8'h02, 8'h00, wf1(1, 6'h2A), 1'b1, 1'b0, 6'h00, 3'd0, 8'h00);
        vt[9]  = mk(8'h02, 8'h02, wf1(1, 6'h11), 1'b0, 1'b0, 6'h00, 3'd0, 8'h02);
        vt[10] = mk(8'h80, 8'h80, wf1(7, 6'h17), 1'b0, 1'b1, 6'h11, 3'd1, 8'h80);
        vt[11] = mk(8'h01, 8'h01, wf1(0, 6'h10), 1'b0, 1'b1, 6'h11, 3'd1, 8'h81);
        vt[12] = mk(8'h00, 8'h00, 48'h0,         1'b1, 1'b1, 6'h17, 3'd7, 8'h01);
        vt[13] = mk(8'h00, 8'h00, 48'h0,         1'b1, 1'b1, 6'h10, 3'd0, 8'h00);
        vt[14] = mk(8'h00, 8'h00, 48'h0,         1'b1, 1'b0, 6'h00, 3'd0, 8'h00);

        // reset with unknown inputs
        rst_n = 1'b0;
        if0.wr_port_select = 'x; if0.wfid_done = 'x; if0.wfid = 'x; if0.out_ready = 'x;
        if1.wr_port_select = 'x; if1.wfid_done = 'x; if1.wfid = 'x; if1.out_ready = 'x;
        #22;
        chk("rst_valid",   64'(if1.out_valid), 64'h0);
        chk("rst_wfid",    64'(if1.out_wfid),  64'h0);
        chk("rst_port",    64'(if1.out_port),  64'h0);
        chk("rst_pend",    64'(if1.pend_mask), 64'h0);
        chk("rst_sel_err", 64'(if1.sel_err),   64'h0);
        chk("rst_ovf_err", 64'(if1.ovf_err),   64'h0);
        chk("rst_valid0",  64'(if0.out_valid), 64'h0);
        chk("rst_pend0",   64'(if0.pend_mask), 64'h0);
        if0.wr_port_select = '0; if0.wfid_done = '0; if0.wfid = '0; if0.out_ready = 1'b1;
        drv1(8'h00, 8'h00, 48'h0, 1'b1);
        rst_n = 1'b1;
        step();
        chk("post_rst_valid", 64'(if1.out_valid), 64'h0);
        chk("post_rst_pend",  64'(if1.pend_mask), 64'h0);

        // all eight ports at once with multi-hot capture allowed
        if0.wr_port_select = 8'hFF;
        if0.wfid_done      = 8'hFF;
        for (int i = 0; i < 8; i++) begin
            if0.wfid[i*6 +: 6] = 6'(i + 8);
        end
        step();
        if0.wr_port_select = '0; if0.wfid_done = '0; if0.wfid = '0;
        chk("burst_pend",  64'(if0.pend_mask), 64'hFF);
        chk("burst_valid", 64'(if0.out_valid), 64'h0);
        for (int i = 0; i < 8; i++) begin
            step();
            chk("burst_beat_valid", 64'(if0.out_valid), 64'h1);
            chk("burst_beat_port",  64'(if0.out_port),  64'(i));
            chk("burst_beat_wfid",  64'(if0.out_wfid),  64'(i + 8));
        end
        step();
        chk("burst_end_valid", 64'(if0.out_valid), 64'h0);
        chk("burst_sel_err",   64'(if0.sel_err),   64'h0);
        chk("burst_ovf_err",   64'(if0.ovf_err),   64'h0);

        // per-cycle vector table: single event, ignored inputs, same-cycle refill, round robin
        for (int i = 0; i < 15; i++) begin
            drv1(vt[i].sel, vt[i].done, vt[i].wfid, vt[i].ready);
            step();
            chk_out1($sformatf("vec%0d", i), vt[i].exp_valid, vt[i].exp_wfid,
                     vt[i].exp_port, vt[i].exp_pend);
            chk($sformatf("vec%0d_ovf", i), 64'(if1.ovf_err), 64'h0);
            chk($sformatf("vec%0d_sel", i), 64'(if1.sel_err), 64'h0);
        end

        // backpressure overflow: output occupied, port 3 hit twice
        drv1(8'h01, 8'h01, wf1(0, 6'h3F), 1'b0);
        step();
        chk_out1("bp_a", 1'b0, 6'h00, 3'd0, 8'h01);
        drv1(8'h00, 8'h00, 48'h0, 1'b0);
        step();
        chk_out1("bp_b", 1'b1, 6'h3F, 3'd0, 8'h00);
        drv1(8'h08, 8'h08, wf1(3, 6'h01), 1'b0);
        step();
        chk_out1("bp_c", 1'b1, 6'h3F, 3'd0, 8'h08);
        chk("bp_c_ovf", 64'(if1.ovf_err), 64'h0);
        drv1(8'h08, 8'h08, wf1(3, 6'h02), 1'b0);
        step();
        chk("bp_d_ovf", 64'(if1.ovf_err), 64'h1);
        chk_out1("bp_d", 1'b1, 6'h3F, 3'd0, 8'h08);
        drv1(8'h00, 8'h00, 48'h0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk_out1("bp_hold", 1'b1, 6'h3F, 3'd0, 8'h08);
        end
        drv1(8'h00, 8'h00, 48'h0, 1'b1);
        step();
        chk_out1("bp_drain", 1'b1, 6'h01, 3'd3, 8'h00);
        step();
        chk_out1("bp_empty", 1'b0, 6'h00, 3'd0, 8'h00);
        step();
        chk_out1("bp_empty2", 1'b0, 6'h00, 3'd0, 8'h00);

        // multi-hot select rejected
        drv1(8'h11, 8'h11, wf1(0, 6'h05) | wf1(4, 6'h06), 1'b1);
        step();
        chk("mh_sel_err", 64'(if1.sel_err), 64'h1);
        chk_out1("mh_a", 1'b0, 6'h00, 3'd0, 8'h00);
        drv1(8'h00, 8'h00, 48'h0, 1'b1);
        step();
        chk_out1("mh_b", 1'b0, 6'h00, 3'd0, 8'h00);

        // async reset mid-drain
        drv1(8'h02, 8'h02, wf1(1, 6'h21), 1'b0);
        step();
        chk_out1("ar_a", 1'b0, 6'h00, 3'd0, 8'h02);
        drv1(8'h04, 8'h04, wf1(2, 6'h22), 1'b0);
        step();
        chk_out1("ar_b", 1'b1, 6'h21, 3'd1, 8'h04);
        drv1(8'h10, 8'h10, wf1(4, 6'h24), 1'b0);
        step();
        drv1(8'h40, 8'h40, wf1(6, 6'h26), 1'b0);
        step();
        chk_out1("ar_c", 1'b1, 6'h21, 3'd1, 8'h54);
        drv1(8'h00, 8'h00, 48'h0, 1'b1);
        step();
        chk_out1("ar_d", 1'b1, 6'h22, 3'd2, 8'h50);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_valid_async", 64'(if1.out_valid), 64'h0);
        chk("ar_pend_async",  64'(if1.pend_mask), 64'h0);
        chk("ar_sel_err",     64'(if1.sel_err),   64'h0);
        chk("ar_ovf_err",     64'(if1.ovf_err),   64'h0);
        step();
        #3;
        rst_n = 1'b1;
        step();
        chk_out1("ar_release", 1'b0, 6'h00, 3'd0, 8'h00);
        step();
        chk_out1("ar_release2", 1'b0, 6'h00, 3'd0, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
